// File: rtl/keypad_entry_ctrl_pkg.sv
// Shared definitions for the keypad entry controller: FSM encoding and key width.
package keypad_entry_ctrl_pkg;

  localparam int KEY_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_PRESSED  = 2'd2,
    ST_RELEASE  = 2'd3
  } state_e;

endpackage

// File: rtl/keypad_entry_ctrl_if.sv
// Scanner-side and consumer-side signals of the keypad entry controller.
interface keypad_entry_ctrl_if #(
  parameter int DEPTH = 4
);
  import keypad_entry_ctrl_pkg::*;

  logic                     key_valid;
  logic [KEY_W-1:0]         key_code;
  logic                     scan_en;
  logic                     out_valid;
  logic [KEY_W-1:0]         out_code;
  logic                     out_ready;
  logic [$clog2(DEPTH):0]   fifo_count;
  logic                     overflow;
  logic                     clr_ovf;

  modport slave (
    input  key_valid, key_code, out_ready, clr_ovf,
    output scan_en, out_valid, out_code, fifo_count, overflow
  );

  modport master (
    output key_valid, key_code, out_ready, clr_ovf,
    input  scan_en, out_valid, out_code, fifo_count, overflow
  );
endinterface

// File: rtl/keypad_entry_ctrl_key_fifo.sv
// First-word-fall-through FIFO for accepted key codes; head reads as zero when empty.
module key_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [DATA_W-1:0]      din,
  output logic [DATA_W-1:0]      dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              do_push, do_pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign dout  = empty ? '0 : mem_q[rd_ptr_q];

  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/keypad_entry_ctrl.sv
// Debounces scanner presses into one entry per press/release and buffers them in a FIFO.
module keypad_entry_ctrl
  import keypad_entry_ctrl_pkg::*;
#(
  parameter int DEB_CYCLES = 4,
  parameter int REL_CYCLES = 4,
  parameter int DEPTH      = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  keypad_entry_ctrl_if.slave   bus
);
  localparam int MAX_C = (DEB_CYCLES > REL_CYCLES) ? DEB_CYCLES : REL_CYCLES;
  localparam int CNT_W = $clog2(MAX_C + 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [KEY_W-1:0] code_q, code_d;
  logic             ovf_q, ovf_d;
  logic             push, pop, fifo_full, fifo_empty;

  assign pop = bus.out_valid && bus.out_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    push    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.key_valid) begin
          code_d  = bus.key_code;
          cnt_d   = '0;
          state_d = ST_DEBOUNCE;
        end
      end
      ST_DEBOUNCE: begin
        if (!bus.key_valid || (bus.key_code != code_q)) begin
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_W'(DEB_CYCLES - 1)) begin
          push    = 1'b1;
          state_d = ST_PRESSED;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_PRESSED: begin
        // Code changes while held are ignored; only a release re-arms the press.
        if (!bus.key_valid) begin
          cnt_d   = '0;
          state_d = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (bus.key_valid) begin
          state_d = ST_PRESSED;
        end else if (cnt_q == CNT_W'(REL_CYCLES - 1)) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A dropped key sets the sticky flag, and that set wins over a same-cycle clear.
  always_comb begin
    ovf_d = ovf_q;
    if (push && fifo_full && !pop) ovf_d = 1'b1;
    else if (bus.clr_ovf)          ovf_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      code_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      ovf_q   <= ovf_d;
    end
  end

  key_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (KEY_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (reset),
    .push  (push),
    .pop   (pop),
    .din   (code_q),
    .dout  (bus.out_code),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (bus.fifo_count)
  );

  assign bus.out_valid = !fifo_empty;
  assign bus.scan_en   = !fifo_full;
  assign bus.overflow  = ovf_q;

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Directed bench for keypad_entry_ctrl with hand-computed expectations.
module tb_keypad_entry_ctrl;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_err;

  keypad_entry_ctrl_if #(.DEPTH(4)) bus ();

  keypad_entry_ctrl #(
    .DEB_CYCLES (4),
    .REL_CYCLES (4),
    .DEPTH      (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] code, input int hold, input int rel);
    bus.key_valid = 1'b1;
    bus.key_code  = code;
    cyc(hold);
    bus.key_valid = 1'b0;
    cyc(rel);
  endtask

  task automatic pop_one();
    bus.out_ready = 1'b1;
    cyc(1);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    logic [3:0] drain_exp [4];
    n_chk = 0;
    n_err = 0;
    reset         = 1'b0;
    bus.key_valid = 1'b0;
    bus.key_code  = 4'h0;
    bus.out_ready = 1'b0;
    bus.clr_ovf   = 1'b0;
    cyc(2);
    chk("rst_count", 32'(bus.fifo_count), 0);
    chk("rst_valid", 32'(bus.out_valid), 0);
    chk("rst_code",  32'(bus.out_code), 0);
    chk("rst_scan",  32'(bus.scan_en), 1);
    chk("rst_ovf",   32'(bus.overflow), 0);
    reset = 1'b1;
    cyc(1);

    // Clean press of 5: push lands on the fifth edge after key_valid rises.
    bus.key_valid = 1'b1;
    bus.key_code  = 4'h5;
    cyc(4);
    chk("clean_before_push", 32'(bus.out_valid), 0);
    cyc(1);
    chk("clean_valid", 32'(bus.out_valid), 1);
    chk("clean_code",  32'(bus.out_code), 5);
    chk("clean_count", 32'(bus.fifo_count), 1);
    cyc(5);
    bus.key_valid = 1'b0;
    cyc(10);
    chk("clean_single", 32'(bus.fifo_count), 1);
    pop_one();
    chk("clean_drained", 32'(bus.fifo_count), 0);
    chk("clean_empty",   32'(bus.out_valid), 0);

    // Bounce rejection, then a code change inside debounce.
    press(4'h9, 3, 1);
    press(4'h9, 3, 5);
    chk("bounce_count", 32'(bus.fifo_count), 0);
    bus.key_valid = 1'b1;
    bus.key_code  = 4'h9;
    cyc(2);
    bus.key_code  = 4'hA;
    cyc(2);
    bus.key_valid = 1'b0;
    cyc(5);
    chk("codechg_count", 32'(bus.fifo_count), 0);

    // Release bounce must not produce a second entry.
    press(4'h3, 6, 2);
    press(4'h3, 5, 6);
    chk("relb_count", 32'(bus.fifo_count), 1);
    chk("relb_code",  32'(bus.out_code), 3);
    pop_one();
    chk("relb_drained", 32'(bus.fifo_count), 0);

    // Fill to full, then overflow on a fifth key.
    for (int i = 1; i <= 4; i++) press(4'(i), 6, 6);
    chk("fill_count", 32'(bus.fifo_count), 4);
    chk("fill_scan",  32'(bus.scan_en), 0);
    press(4'h5, 6, 6);
    chk("ovf_flag",  32'(bus.overflow), 1);
    chk("ovf_head",  32'(bus.out_code), 1);
    chk("ovf_count", 32'(bus.fifo_count), 4);
    bus.clr_ovf = 1'b1;
    cyc(1);
    bus.clr_ovf = 1'b0;
    chk("ovf_clear", 32'(bus.overflow), 0);

    // Full with a pop on the push edge: both happen, no overflow.
    bus.key_valid = 1'b1;
    bus.key_code  = 4'h5;
    cyc(4);
    bus.out_ready = 1'b1;
    cyc(1);
    bus.out_ready = 1'b0;
    chk("fullpop_count", 32'(bus.fifo_count), 4);
    chk("fullpop_ovf",   32'(bus.overflow), 0);
    drain_exp = '{4'h2, 4'h3, 4'h4, 4'h5};
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drain%0d", i), 32'(bus.out_code), 32'(drain_exp[i]));
      pop_one();
    end
    chk("drain_empty", 32'(bus.out_valid), 0);
    chk("drain_scan",  32'(bus.scan_en), 1);
    bus.key_valid = 1'b0;
    cyc(6);

    // Async reset mid-debounce with two entries buffered and overflow set.
    press(4'h7, 6, 6);
    press(4'h8, 6, 6);
    press(4'h1, 6, 6);
    press(4'h2, 6, 6);
    press(4'h4, 6, 6);
    chk("pre_rst_ovf", 32'(bus.overflow), 1);
    pop_one();
    pop_one();
    chk("pre_rst_count", 32'(bus.fifo_count), 2);
    bus.key_valid = 1'b1;
    bus.key_code  = 4'h9;
    cyc(2);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_count", 32'(bus.fifo_count), 0);
    chk("arst_valid", 32'(bus.out_valid), 0);
    chk("arst_scan",  32'(bus.scan_en), 1);
    chk("arst_ovf",   32'(bus.overflow), 0);
    chk("arst_code",  32'(bus.out_code), 0);
    bus.key_valid = 1'b0;
    cyc(1);
    reset = 1'b1;
    cyc(1);
    // From IDLE a fresh key 6 needs the full debounce latency.
    bus.key_valid = 1'b1;
    bus.key_code  = 4'h6;
    cyc(4);
    chk("post_rst_latency", 32'(bus.out_valid), 0);
    cyc(1);
    chk("post_rst_valid", 32'(bus.out_valid), 1);
    chk("post_rst_code",  32'(bus.out_code), 6);
    bus.key_valid = 1'b0;
    cyc(6);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/keypad_entry_ctrl.md
Name: keypad_entry_ctrl

Overview:
Sequencing controller between the hex keypad scanner (code/valid) and downstream consumers. It debounces each press and emits exactly one entry per press-release cycle. Accepted codes are buffered in a small FIFO with a ready/valid output, and the controller gates the scanner through scan_en when the buffer cannot accept more keys. A sticky overflow flag reports dropped keys.

Parameters:
DEB_CYCLES, 4, consecutive stable-valid samples (after the first) required to accept a press; legal range >=1.
REL_CYCLES, 4, consecutive invalid samples required to declare release; legal range >=1.
DEPTH, 4, FIFO entries; must be a power of 2, >=2.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
key_valid  input  1  scanner valid, already synchronized
key_code  input  4  scanner code, meaningful when key_valid=1
scan_en  output  1  1 = scanner may run; 0 while FIFO is full
out_valid  output  1  FIFO non-empty
out_code  output  4  FIFO head, first-word-fall-through
out_ready  input  1  consumer accepts head when out_valid=1
fifo_count  output  $clog2(DEPTH)+1  entries held
overflow  output  1  sticky: a debounced key was dropped
clr_ovf  input  1  synchronous clear of overflow

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (port reset, clock clk).
- Reset state (reset=0): FSM=IDLE, counter=0, latched code=0, FIFO empty, out_valid=0, out_code=0, fifo_count=0, overflow=0, scan_en=1. Asserting reset mid-press discards the press and all buffered entries.
- FSM states: IDLE, DEBOUNCE, PRESSED, RELEASE.
- IDLE: on key_valid=1, latch key_code, set cnt=0, go to DEBOUNCE.
- DEBOUNCE: if key_valid=0 or key_code != latched code, return to IDLE with no push. Otherwise, if cnt==DEB_CYCLES-1, push the latched code and go to PRESSED; else cnt++.
- PRESSED: on key_valid=0, set cnt=0 and go to RELEASE. Code changes while held are ignored, so there is no second push without a release.
- RELEASE: on key_valid=1, return to PRESSED (bounce, no push). On cnt==REL_CYCLES-1, go to IDLE; else cnt++.
- Latency: key_valid first sampled high at edge 0 with a stable code gives a push at edge DEB_CYCLES. If the FIFO was empty, out_valid=1 and out_code is valid after that edge.
- Pop: occurs at an edge where out_valid=1 and out_ready=1. out_ready is ignored when the FIFO is empty.
- Push with FIFO not full: the entry is written at the tail.
- Push with FIFO full and no pop in the same cycle: the entry is dropped, overflow is set to 1, and the FSM still goes to PRESSED.
- Push with FIFO full and a pop in the same cycle: both occur, count is unchanged, overflow is not set.
- Simultaneous push and pop with FIFO not full: count is unchanged.
- Pointers are $clog2(DEPTH) bits wide and wrap modulo DEPTH. fifo_count ranges 0..DEPTH.
- scan_en = (fifo_count != DEPTH), registered-state-derived combinational output.
- overflow: if clr_ovf and a new overflow event occur in the same cycle, the set wins. Otherwise clr_ovf=1 clears it at the next edge.
- All outputs are driven from registers or simple decode of registers. There is no combinational path from out_ready to out_valid.

Decomposition:
- Shared package holds the FSM state encoding (2-bit constants ST_IDLE=0, ST_DEBOUNCE=1, ST_PRESSED=2, ST_RELEASE=3) and the 4-bit key-code width constant used by the scanner.
- One natural sub-module: key_fifo (parameterized DEPTH x 4-bit FWFT FIFO exposing push, pop, full, empty and count).
- The FSM, debounce counter and overflow logic live in the top module.

Test Plan:
- Clean press: after reset release, hold key_valid=1, key_code=4'h5 for 10 cycles, then 0 for 10 cycles, with out_ready=0 → exactly one push at edge 4, then out_valid=1, out_code=5, fifo_count=1; no further push after release.
- Bounce reject: key_valid=1 with code 4'h9 for 3 cycles, 0 for 1 cycle, then 1 for 3 cycles → no push, fifo_count=0. A code change from 4'h9 to 4'hA inside DEBOUNCE also gives no push.
- Release bounce: after accepting 4'h3, drop key_valid for 2 cycles, reassert for 5 cycles, then release for 6 cycles → only one 4'h3 entry total.
- Fill and overflow: with out_ready=0, press codes 1, 2, 3, 4 → fifo_count=4 and scan_en=0. A fifth press (code 5) → dropped, overflow=1, and the head remains 1. clr_ovf=1 for one cycle → overflow=0.
- Full with simultaneous pop: with the FIFO full, set out_ready=1 on the cycle of the 5th push → count stays 4, overflow stays 0, and codes drain in order 2, 3, 4, 5 across pointer wrap.
- Async reset mid-operation: pull reset low between clock edges while in DEBOUNCE with 2 entries buffered → all outputs immediately go to their reset values (fifo_count=0, out_valid=0, scan_en=1, overflow=0), and the FSM is in IDLE after reset is released.
